uart_hamming_tx: RTL and testbench
==================================

Name: uart_hamming_tx

Overview:
Serial transmitter paired with the Hamming(7,4) UART receiver on the same link. Accepts a 4-bit nibble over a valid/ready handshake and encodes it to a 7-bit Hamming codeword. Sends the codeword as one frame: start bit, 7 data bits LSB first, stop bit(s). Bit timing is CLKS_PER_BIT enabled clocks per bit, matching the receiver's 8x oversampling.

Parameters:
CLKS_PER_BIT, 8, enabled clock cycles per serial bit; legal range 2..255.
STOP_BITS, 1, number of stop bits per frame; legal values 1 or 2.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  clock enable, active high; when low, all state freezes
data_in  input  4  nibble to send, d[3:0]
valid_in  input  1  data_in is valid
ready_out  output  1  transmitter can accept a nibble
tx  output  1  serial line; idle high
state_out  output  2  current FSM state, for debug
busy_out  output  1  a frame is in progress (state != IDLE)

Behaviour:
- Reset (async, rst_n low): tx=1, state=IDLE, state_out=2'b00, ready_out=1, busy_out=0. Counters and codeword register are cleared.
- Reset applied mid-frame aborts the frame immediately. tx returns to 1 and no partial-frame recovery occurs.
- ena low: FSM, counters, shift register and tx hold their values. No handshake completes.
- Handshake: a transfer occurs on a rising edge where ena && valid_in && ready_out.
- ready_out = (state==IDLE) when TX_HOLD_BUFFER_EN is undefined.
- Encoding is registered at the transfer edge:
  - p1 = d0^d1^d3; p2 = d0^d2^d3; p3 = d1^d2^d3.
  - codeword c[6:0] = {d3,d2,d1,p3,d0,p2,p1}.
- FSM encoding: IDLE=00, START=01, DATA=10, STOP=11.
- IDLE: tx=1. On transfer, go to START and clear clk_cnt.
- START: tx=0 for CLKS_PER_BIT enabled cycles, then go to DATA with bit_cnt=0.
- DATA: tx=c[bit_cnt] for CLKS_PER_BIT enabled cycles per bit.
  - After bit_cnt=6 completes, go to STOP.
  - Otherwise increment bit_cnt and shift.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT enabled cycles, then go to IDLE (or START directly, see optional feature).
- tx is a registered output.
  - First start-bit cycle appears one clock after the transfer edge.
  - Frame length is (8+STOP_BITS)*CLKS_PER_BIT enabled cycles: 72 with defaults.
- clk_cnt wraps from CLKS_PER_BIT-1 to 0 on each bit boundary. bit_cnt is 3 bits, range 0..6, and never reaches 7.
- valid_in asserted during a frame without the hold buffer: ignored. data_in is not sampled.
- data_in changing after the transfer edge has no effect on the frame in flight.
- Illegal state value: go to IDLE with tx=1.

Optional Feature:
Macro: TX_HOLD_BUFFER_EN
- Defined: adds a one-entry holding register for the next encoded codeword.
  - ready_out = !hold_full.
  - A nibble may be accepted while a frame is in progress.
  - At the end of the last stop-bit cycle with hold_full=1, go directly to START (no idle gap), load the held codeword, and clear hold_full.
  - A transfer and an unload on the same edge: the new nibble goes into the freed hold slot and hold_full stays 1.
  - Reset clears hold_full.
- Undefined: no hold register. ready_out is high only in IDLE, and consecutive frames have at least one idle-high cycle between them.

Test Plan:
- Reset with rst_n=0 mid-DATA -> tx=1, state_out=00, ready_out=1, busy_out=0 on the same cycle, asynchronously.
- data_in=4'b1011, valid_in pulse, ena=1, defaults -> codeword 7'b1010101. tx = 0 for 8 cycles, then 1,0,1,0,1,0,1 (8 cycles each), then 1 for 8 cycles. busy_out is high for 72 cycles.
- data_in=4'b0000, then 4'b1111 -> data bits all 0, then all 1. The receiver model decodes 7'b0000000 and 7'b1111111 with valid_out=1.
- ena toggled 50% during a frame -> every bit lasts exactly 8 enabled cycles. tx is frozen during ena=0 and the total frame is 144 clocks.
- valid_in held high during a frame, macro undefined -> only the first nibble is sent. ready_out=0 until IDLE, and there is at least one idle-high cycle before the next start bit.
- TX_HOLD_BUFFER_EN defined, two nibbles back-to-back -> the second is accepted mid-frame and ready_out drops. The second start bit follows the first stop bit with no idle cycle.

Source files
------------

// File: rtl/uart_hamming_tx.sv
// uart_hamming_tx: Hamming(7,4) encoding UART transmitter, start + 7 data bits LSB first + stop bit(s).
// Optional one-entry codeword hold buffer enabled by defining TX_HOLD_BUFFER_EN.
module uart_hamming_tx #(
    parameter int CLKS_PER_BIT = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [3:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx,
    output logic [1:0] state_out,
    output logic       busy_out
);
    typedef enum logic [1:0] {IDLE = 2'b00, START = 2'b01, DATA = 2'b10, STOP = 2'b11} state_t;

    state_t     state_q;
    logic [7:0] clk_cnt_q;
    logic [2:0] bit_cnt_q;
    logic [6:0] shift_q;
    logic       tx_q;
    logic [6:0] cw_d;
    logic       xfer;
    logic       bit_done;
    logic       last_stop;

    function automatic logic [6:0] encode(input logic [3:0] d);
        return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
    endfunction

    assign cw_d      = encode(data_in);
    assign xfer      = ena && valid_in && ready_out;
    assign bit_done  = clk_cnt_q == 8'(CLKS_PER_BIT - 1);
    assign last_stop = bit_done && bit_cnt_q == 3'(STOP_BITS - 1);

`ifdef TX_HOLD_BUFFER_EN
    logic       hold_full_q;
    logic [6:0] hold_q;
    assign ready_out = !hold_full_q;
`else
    assign ready_out = state_q == IDLE;
`endif

    assign tx        = tx_q;
    assign state_out = state_q;
    assign busy_out  = state_q != IDLE;

    // Frame sequencer: bit timing, codeword shifting and the registered serial line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
`ifdef TX_HOLD_BUFFER_EN
            hold_full_q <= 1'b0;
            hold_q      <= '0;
`endif
        end else if (ena) begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (xfer) begin
                        state_q   <= START;
                        clk_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        shift_q   <= cw_d;
                        tx_q      <= 1'b0;
                    end
                end
                START: begin
                    clk_cnt_q <= bit_done ? 8'd0 : clk_cnt_q + 8'd1;
                    if (bit_done) begin
                        state_q   <= DATA;
                        bit_cnt_q <= '0;
                        tx_q      <= shift_q[0];
                    end
                end
                DATA: begin
                    clk_cnt_q <= bit_done ? 8'd0 : clk_cnt_q + 8'd1;
                    if (bit_done) begin
                        if (bit_cnt_q == 3'd6) begin
                            state_q   <= STOP;
                            bit_cnt_q <= '0;
                            tx_q      <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[6:1]};
                            tx_q      <= shift_q[1];
                        end
                    end
                end
                STOP: begin
                    clk_cnt_q <= bit_done ? 8'd0 : clk_cnt_q + 8'd1;
                    if (last_stop) begin
                        bit_cnt_q <= '0;
`ifdef TX_HOLD_BUFFER_EN
                        if (hold_full_q) begin
                            state_q <= START;
                            shift_q <= hold_q;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
`else
                        state_q <= IDLE;
`endif
                    end else if (bit_done) begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    clk_cnt_q <= '0;
                    bit_cnt_q <= '0;
                    tx_q      <= 1'b1;
                end
            endcase
`ifdef TX_HOLD_BUFFER_EN
            // A nibble taken mid-frame parks in the hold slot; the slot empties when the next frame starts from it.
            if (xfer && state_q != IDLE) begin
                hold_q      <= cw_d;
                hold_full_q <= 1'b1;
            end else if (state_q == STOP && last_stop && hold_full_q) begin
                hold_full_q <= 1'b0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_uart_hamming_tx.sv
// tb_uart_hamming_tx: directed scoreboard bench for uart_hamming_tx with default parameters.
module tb_uart_hamming_tx;
    localparam int C = 8;
    localparam int FRAME = 9 * C;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [3:0] data_in = '0;
    logic       valid_in = 1'b0;
    logic       ready_out;
    logic       tx;
    logic [1:0] state_out;
    logic       busy_out;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [3:0] sb[$];

    uart_hamming_tx #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .tx(tx), .state_out(state_out), .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    // Free-running clock counter used to measure frame duration.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] enc(input logic [3:0] d);
        return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
    endfunction

    function automatic logic [4:0] rx_decode(input logic [6:0] c);
        logic [2:0] s;
        s = {c[3] ^ c[4] ^ c[5] ^ c[6], c[1] ^ c[2] ^ c[5] ^ c[6], c[0] ^ c[2] ^ c[4] ^ c[6]};
        return {s == 3'd0, c[6], c[5], c[4], c[2]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send(input logic [3:0] d, input bit keep_valid);
        int n;
        n = 0;
        data_in = d;
        valid_in = 1'b1;
        while (!(ready_out && ena) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("send_ready_timeout", 32'(n < 300), 1);
        @(posedge clk);
        if (n < 300) sb.push_back(d);
        @(negedge clk);
        if (!keep_valid) valid_in = 1'b0;
    endtask

    // Checks the line for enabled-cycle indices first..FRAME-1 against the scoreboard head.
    task automatic frame(input string tag, input int first, input bit tog, output logic [6:0] cw);
        int bad;
        int bi;
        logic e;
        logic [3:0] n;
        logic [6:0] ecw;
        bad = 0;
        cw = '0;
        n = sb.size() != 0 ? sb.pop_front() : 4'bx;
        ecw = enc(n);
        for (int i = first; i < FRAME; i++) begin
            bi = i / C;
            e = bi == 0 ? 1'b0 : bi == 8 ? 1'b1 : ecw[bi-1];
            if (tx !== e || busy_out !== 1'b1) bad++;
`ifndef TX_HOLD_BUFFER_EN
            if (ready_out !== 1'b0) bad++;
`endif
            if (bi >= 1 && bi <= 7 && i % C == C / 2) cw[bi-1] = tx;
            if (tog) begin
                ena = 1'b0;
                @(negedge clk);
                if (tx !== e) bad++;
                ena = 1'b1;
            end
            @(negedge clk);
        end
        check({tag, "_wave"}, bad, 0);
        check({tag, "_cw"}, cw, ecw);
    endtask

    task automatic idle_chk(input string tag);
        check({tag, "_tx"}, tx, 1);
        check({tag, "_state"}, state_out, 0);
        check({tag, "_busy"}, busy_out, 0);
        check({tag, "_ready"}, ready_out, 1);
    endtask

    initial begin
        logic [6:0] cw;
        int c0;
        repeat (3) @(negedge clk);
        idle_chk("reset");
        rst_n = 1'b1;
        @(negedge clk);

        send(4'b1011, 0);
        frame("f1011", 0, 0, cw);
        check("f1011_literal", cw, 7'b1010101);
        check("f1011_rx", rx_decode(cw), 5'b11011);
        idle_chk("f1011_end");

        send(4'b0000, 0);
        frame("f0000", 0, 0, cw);
        check("f0000_rx", rx_decode(cw), 5'b10000);
        send(4'b1111, 0);
        frame("f1111", 0, 0, cw);
        check("f1111_rx", rx_decode(cw), 5'b11111);
        idle_chk("f1111_end");

        send(4'b0110, 0);
        c0 = cyc;
        frame("ftog", 0, 1, cw);
        check("ftog_clocks", cyc - c0, 2 * FRAME);
        idle_chk("ftog_end");

`ifndef TX_HOLD_BUFFER_EN
        send(4'b1001, 1);
        data_in = 4'b0011;
        frame("fheld", 0, 0, cw);
        idle_chk("fheld_gap");
        send(4'b0011, 0);
        frame("fnext", 0, 0, cw);
        idle_chk("fnext_end");
`else
        send(4'b1100, 0);
        data_in = 4'b0111;
        valid_in = 1'b1;
        @(posedge clk);
        sb.push_back(4'b0111);
        @(negedge clk);
        valid_in = 1'b0;
        check("hold_ready_drop", ready_out, 0);
        frame("fh1", 1, 0, cw);
        check("hold_no_gap_tx", tx, 0);
        check("hold_no_gap_state", state_out, 1);
        frame("fh2", 0, 0, cw);
        idle_chk("fh2_end");
`endif

        send(4'b0101, 0);
        repeat (20) @(negedge clk);
        check("mid_state", state_out, 2);
        #2 rst_n = 1'b0;
        #1 idle_chk("async_rst");
        void'(sb.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        idle_chk("post_rst");

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
